// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit serializer.
// UART_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    // Rounded clock cycles per bit.
    function automatic int calc_baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the send-sequencing stage and the serializer.
interface uart_tx_serializer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled, ticks on the last count.
module uart_baud_counter #(
    parameter int BAUD_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] TC = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !enable || cnt == TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = enable && (cnt == TC);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit back end: byte FIFO feeding an 8N1 serializer with a per-frame done pulse.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_serializer_if.slave  s_if,
    output logic                 tx,
    output logic                 busy,
    output logic                 data_ready
);

    localparam int BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;

    state_t     state;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic       bit_tick;
    logic       push;
    logic       pop;
    logic       empty;
`ifdef UART_TX_PARITY_EN
    logic       par_bit;
`endif

    assign empty = (count == '0);
    assign push  = s_if.tx_valid && s_if.tx_ready;
    // Pop either from idle or at the stop-bit boundary so frames run back to back.
    assign pop   = !empty && ((state == ST_IDLE) || (state == ST_STOP && bit_tick));
    assign busy  = (state != ST_IDLE) || !empty;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            s_if.tx_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count         <= count_next;
            s_if.tx_ready <= (count_next != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_if.tx_data;
    end

    uart_baud_counter #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (pop),
        .enable   (state != ST_IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            tx         <= 1'b1;
            data_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            data_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                        par_bit <= ^mem[rd_ptr];
`endif
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    tx <= 1'b0;
                    if (bit_tick) state <= ST_DATA;
                end
                ST_DATA: begin
                    tx <= shift[0];
                    if (bit_tick) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    tx <= par_bit;
                    if (bit_tick) state <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    tx <= 1'b1;
                    if (bit_tick) begin
                        data_ready <= 1'b1;
                        if (pop) begin
                            shift   <= mem[rd_ptr];
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            par_bit <= ^mem[rd_ptr];
`endif
                            state   <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at BAUD_DIV=10, with a line monitor decoding frames.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int BD = 10;
    localparam int FL = NB * BD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic busy;
    logic data_ready;

    uart_tx_serializer_if ifc ();

    uart_tx_serializer #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_if       (ifc),
        .tx         (tx),
        .busy       (busy),
        .data_ready (data_ready)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // line monitor state
    bit          mon_busy = 1'b0;
    logic        prev_tx  = 1'b1;
    int          phase    = 0;
    logic [NB-1:0] bits;
    bit          glitch;
    logic [7:0]  rx_q [$];
    logic        par_q [$];
    int          fall_q [$];
    int          dr_count    = 0;
    int          dr_bad      = 0;
    int          frame_bad   = 0;
    int          last_dr_cyc = 0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            mon_busy = 1'b0;
            prev_tx  = 1'b1;
        end else begin
            if (!mon_busy && prev_tx === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                phase    = 0;
                glitch   = 1'b0;
                fall_q.push_back(cyc);
            end else if (mon_busy) begin
                phase++;
            end
            if (mon_busy) begin
                if (phase % BD == 0) bits[phase / BD] = tx;
                else if (tx !== bits[phase / BD]) glitch = 1'b1;
            end
            if (data_ready === 1'b1) begin
                dr_count++;
                last_dr_cyc = cyc;
                if (!(mon_busy && phase == FL - 1)) dr_bad++;
            end
            if (mon_busy && phase == FL - 1) begin
                if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1 || glitch) frame_bad++;
                rx_q.push_back(bits[8:1]);
`ifdef UART_TX_PARITY_EN
                par_q.push_back(bits[9]);
`endif
                mon_busy = 1'b0;
            end
            prev_tx = tx;
        end
    end

    task automatic check(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        ifc.tx_data  = b;
        ifc.tx_valid = 1'b1;
        while (ifc.tx_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (ifc.tx_ready !== 1'b1) check("push_timeout", ifc.tx_ready, 1);
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic wait_rx(input int n);
        int t;
        t = 0;
        while (rx_q.size() < n && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("wait_rx", rx_q.size(), n);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("wait_idle", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int a, nf, nr, ndr, acc5, acc6, f0, d0;
        logic [7:0] seq [7];
        seq[0] = 8'h11; seq[1] = 8'hC3; seq[2] = 8'h96; seq[3] = 8'h0F;
        seq[4] = 8'hE1; seq[5] = 8'h3C; seq[6] = 8'h78;

        ifc.tx_valid = 1'b0;
        ifc.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_tx_ready", ifc.tx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_data_ready", data_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", ifc.tx_ready, 1);

        // single byte 0xA5
        nf = fall_q.size();
        push(8'hA5, a);
        ifc.tx_valid = 1'b0;
        wait_rx(1);
        check("a5_latency", fall_q[nf] - a, 2);
        check("a5_data", rx_q[0], 8'hA5);
        check("a5_frame_shape", frame_bad, 0);
        check("a5_dr_count", dr_count, 1);
        check("a5_dr_pos", last_dr_cyc - fall_q[nf], FL - 1);
        check("a5_busy_drop", busy, 0);
        wait_idle();

        // three bytes back to back
        nf = fall_q.size();
        nr = rx_q.size();
        push(8'h47, a);
        push(8'h31, a);
        push(8'h5A, a);
        ifc.tx_valid = 1'b0;
        wait_rx(nr + 3);
        check("b2b_d0", rx_q[nr], 8'h47);
        check("b2b_d1", rx_q[nr + 1], 8'h31);
        check("b2b_d2", rx_q[nr + 2], 8'h5A);
        check("b2b_gap01", fall_q[nf + 1] - fall_q[nf], FL);
        check("b2b_gap12", fall_q[nf + 2] - fall_q[nf + 1], FL);
        check("b2b_dr_count", dr_count, 4);
        check("b2b_dr_pos", dr_bad, 0);
        check("b2b_frame_shape", frame_bad, 0);
        wait_idle();

        // FIFO fill with valid held high while a frame is running
        nr = rx_q.size();
        push(seq[0], a);
        ifc.tx_valid = 1'b0;
        repeat (20) @(negedge clk);
        push(seq[1], a);
        push(seq[2], a);
        push(seq[3], a);
        check("fill_ready_at_3", ifc.tx_ready, 1);
        push(seq[4], a);
        check("fill_full_at_4", ifc.tx_ready, 0);
        push(seq[5], acc5);
        check("fill_acc5_after_pop", acc5, last_dr_cyc + 1);
        check("fill_full_again", ifc.tx_ready, 0);
        push(seq[6], acc6);
        check("fill_acc6_after_pop", acc6, last_dr_cyc + 1);
        ifc.tx_valid = 1'b0;
        wait_rx(nr + 7);
        for (int i = 0; i < 7; i++) check($sformatf("fill_order_%0d", i), rx_q[nr + i], seq[i]);
        check("fill_dr_count", dr_count, 11);
        check("fill_frame_shape", frame_bad, 0);
        wait_idle();

        // byte 0x00
        nr = rx_q.size();
        push(8'h00, a);
        ifc.tx_valid = 1'b0;
        wait_rx(nr + 1);
        check("zero_data", rx_q[nr], 8'h00);
        check("zero_frame_shape", frame_bad, 0);
        check("zero_dr_count", dr_count, 12);
        check("zero_dr_pos", last_dr_cyc - fall_q[fall_q.size() - 1], FL - 1);
        wait_idle();

        // reset during data bit 3 of 0xFF, with a second byte queued
        nf = fall_q.size();
        push(8'hFF, a);
        push(8'h3C, a);
        ifc.tx_valid = 1'b0;
        while (fall_q.size() == nf && cyc < a + 50) @(negedge clk);
        check("rst_fall_seen", fall_q.size(), nf + 1);
        repeat (44) @(negedge clk);
        d0 = dr_count;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_tx_async", tx, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", ifc.tx_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rel_ready_low", ifc.tx_ready, 0);
        f0 = fall_q.size();
        @(posedge clk);
        #1;
        check("rel_ready_high", ifc.tx_ready, 1);
        check("rel_busy", busy, 0);
        repeat (150) @(negedge clk);
        check("rel_no_dr", dr_count, d0);
        check("rel_no_frame", fall_q.size(), f0);
        check("rel_tx_idle", tx, 1);
        check("rel_busy_late", busy, 0);

`ifdef UART_TX_PARITY_EN
        nr = rx_q.size();
        push(8'h07, a);
        ifc.tx_valid = 1'b0;
        wait_rx(nr + 1);
        check("par07_data", rx_q[nr], 8'h07);
        check("par07_bit", par_q[par_q.size() - 1], 1);
        check("par07_len", last_dr_cyc - fall_q[fall_q.size() - 1], 109);
        wait_idle();
        nr = rx_q.size();
        push(8'h03, a);
        ifc.tx_valid = 1'b0;
        wait_rx(nr + 1);
        check("par03_data", rx_q[nr], 8'h03);
        check("par03_bit", par_q[par_q.size() - 1], 0);
        check("par_frame_shape", frame_bad, 0);
        wait_idle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
